// File: rtl/mux_n_reg.sv
// Registered N-way multiplexor: picks one input channel by explicit select or
// round-robin arbitration and holds the chosen beat in a valid/ready output register.
module mux_n_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] iData,
  input  logic [NUM_CH-1:0]            iValid,
  output logic [NUM_CH-1:0]            oReady,
  input  logic                         iMode,
  input  logic [SEL_WIDTH-1:0]         iSel,
  output logic [DATA_WIDTH-1:0]        oData,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [SEL_WIDTH-1:0]         oSel
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_WIDTH-1:0] chData [NUM_CH];
  logic [CH_W-1:0]       rrPtr;
  logic [CH_W-1:0]       candCh;
  logic [CH_W-1:0]       scanCh;
  logic                  candValid;
  logic                  loadEn;
  logic                  inXfer;

  for (genvar k = 0; k < NUM_CH; k++) begin : gUnpack
    assign chData[k] = iData[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign loadEn = !oValid || iReady;

  // Candidate selection: explicit index (bounded by NUM_CH) or the first valid
  // channel after the last round-robin winner, wrapping around.
  always_comb begin
    candValid = 1'b0;
    candCh    = '0;
    scanCh    = '0;
    if (!iMode) begin
      if (int'(iSel) < NUM_CH) begin
        candValid = 1'b1;
        candCh    = CH_W'(iSel);
      end
    end else begin
      for (int off = 1; off <= NUM_CH; off++) begin
        scanCh = CH_W'((int'(rrPtr) + off) % NUM_CH);
        if (!candValid && iValid[scanCh]) begin
          candValid = 1'b1;
          candCh    = scanCh;
        end
      end
    end
  end

  always_comb begin
    oReady = '0;
    if (candValid) begin
      oReady[candCh] = loadEn;
    end
  end

  assign inXfer = candValid && loadEn && iValid[candCh];

  // A new beat overwrites the held one in the same cycle it drains, so there is no bubble.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oValid <= 1'b0;
      oData  <= '0;
      oSel   <= '0;
    end else if (inXfer) begin
      oValid <= 1'b1;
      oData  <= chData[candCh];
      oSel   <= SEL_WIDTH'(candCh);
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

  // Pointer only advances on round-robin grants; explicit transfers leave fairness untouched.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rrPtr <= CH_W'(NUM_CH - 1);
    end else if (inXfer && iMode) begin
      rrPtr <= candCh;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Testbench for mux_n_reg: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mux_n_reg;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int SW  = 3;

  logic              iClk;
  logic              iReset_n;
  logic [NCH*DW-1:0] iData;
  logic [NCH-1:0]    iValid;
  logic [NCH-1:0]    oReady;
  logic              iMode;
  logic [SW-1:0]     iSel;
  logic [DW-1:0]     oData;
  logic              oValid;
  logic              iReady;
  logic [SW-1:0]     oSel;

  logic [DW-1:0] chDataTb [NCH];
  int            checkCount;
  int            passCount;
  logic          compareOn;

  logic          mValid;
  logic [DW-1:0] mData;
  int            mSel;
  int            mPtr;

  mux_n_reg #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SEL_WIDTH(SW)) dut (
    .iClk    (iClk),
    .iReset_n(iReset_n),
    .iData   (iData),
    .iValid  (iValid),
    .oReady  (oReady),
    .iMode   (iMode),
    .iSel    (iSel),
    .oData   (oData),
    .oValid  (oValid),
    .iReady  (iReady),
    .oSel    (oSel)
  );

  assign iData = {chDataTb[3], chDataTb[2], chDataTb[1], chDataTb[0]};

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic bit bitOf(input logic [NCH-1:0] v, input int k);
    return ((v >> k) & 4'd1) != 4'd0;
  endfunction

  // Channel the rules say should be offered this cycle, or -1 for none.
  function automatic int candidate(input logic [NCH-1:0] v, input logic m,
                                   input logic [SW-1:0] s, input int ptr);
    if (!m) return (int'(s) < NCH) ? int'(s) : -1;
    for (int off = 1; off <= NCH; off++) begin
      if (bitOf(v, (ptr + off) % NCH)) return (ptr + off) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] expReady();
    int c;
    c = candidate(iValid, iMode, iSel, mPtr);
    if (c >= 0 && (!mValid || iReady)) return 4'b0001 << c;
    return '0;
  endfunction

  always @(posedge iClk or negedge iReset_n) begin : model
    int c;
    if (!iReset_n) begin
      mValid = 1'b0;
      mData  = '0;
      mSel   = 0;
      mPtr   = NCH - 1;
    end else begin
      c = candidate(iValid, iMode, iSel, mPtr);
      if (c >= 0 && (!mValid || iReady) && bitOf(iValid, c)) begin
        mValid = 1'b1;
        mData  = chDataTb[c[1:0]];
        mSel   = c;
        if (iMode) mPtr = c;
      end else if (mValid && iReady) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge iClk) begin
    if (compareOn) begin
      checkOutput("cmp_ready", 32'(oReady), 32'(expReady()));
      checkOutput("cmp_valid", 32'(oValid), 32'(mValid));
      checkOutput("cmp_data",  oData,       mData);
      checkOutput("cmp_sel",   32'(oSel),   32'(mSel));
    end
  end

  task automatic applyStimulus(input logic [NCH-1:0] v, input logic m,
                               input logic [SW-1:0] s, input logic r);
    iValid = v;
    iMode  = m;
    iSel   = s;
    iReady = r;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  int rrSeq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int altSeq [4] = '{1, 3, 1, 3};

  initial begin
    checkCount = 0;
    passCount  = 0;
    compareOn  = 1'b0;
    iReset_n   = 1'b0;
    applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
    chDataTb[0] = 32'h1111_0000;
    chDataTb[1] = 32'h2222_0001;
    chDataTb[2] = 32'hA5A5_0002;
    chDataTb[3] = 32'h3333_0003;

    tick();
    compareOn = 1'b1;
    checkOutput("rst_valid", 32'(oValid), 32'd0);
    checkOutput("rst_data",  oData,       32'd0);
    checkOutput("rst_sel",   32'(oSel),   32'd0);
    #3 iReset_n = 1'b1;
    tick();

    // Explicit select, then an out-of-range select.
    applyStimulus(4'b1111, 1'b0, 3'd2, 1'b1);
    #1 checkOutput("exp_ready", 32'(oReady), 32'h4);
    tick();
    checkOutput("exp_valid", 32'(oValid), 32'd1);
    checkOutput("exp_data",  oData,       32'hA5A5_0002);
    checkOutput("exp_sel",   32'(oSel),   32'd2);
    applyStimulus(4'b1111, 1'b0, 3'd5, 1'b1);
    #1 checkOutput("exp_oor_ready", 32'(oReady), 32'd0);
    tick();

    // Reset while a beat is held.
    applyStimulus(4'b1111, 1'b0, 3'd1, 1'b0);
    tick();
    checkOutput("held_valid", 32'(oValid), 32'd1);
    applyStimulus(4'b1111, 1'b1, 3'd0, 1'b0);
    #1 iReset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(oValid), 32'd0);
    checkOutput("midrst_data",  oData,       32'd0);
    checkOutput("midrst_sel",   32'(oSel),   32'd0);
    checkOutput("midrst_ready", 32'(oReady), 32'h1);
    iReady   = 1'b1;
    iReset_n = 1'b1;
    tick();
    checkOutput("rr_first", 32'(oSel), 32'd0);

    // Round-robin fairness with all channels valid, then an alternating pair.
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("rr_seq",   32'(oSel),   32'(rrSeq[i]));
      checkOutput("rr_valid", 32'(oValid), 32'd1);
    end
    applyStimulus(4'b1010, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rr_alt", 32'(oSel), 32'(altSeq[i]));
    end

    // Backpressure: the held beat must not move while iReady is low.
    chDataTb[0] = 32'h0000_1234;
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("bp_load", oData, 32'h0000_1234);
    chDataTb[0] = 32'hBEEF_0000;
    applyStimulus(4'b1111, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("bp_ready", 32'(oReady), 32'd0);
      tick();
      checkOutput("bp_data", oData, 32'h0000_1234);
      checkOutput("bp_sel",  32'(oSel), 32'd0);
    end
    iReady = 1'b1;
    #1 checkOutput("bp_release_ready", 32'(oReady), 32'h1);
    tick();
    checkOutput("bp_new_data", oData, 32'hBEEF_0000);

    // Explicit transfers in the middle of round-robin must not move the pointer.
    applyStimulus(4'b1111, 1'b1, 3'd0, 1'b1);
    tick();
    checkOutput("ms_rr1", 32'(oSel), 32'd1);
    applyStimulus(4'b1111, 1'b0, 3'd3, 1'b1);
    tick();
    checkOutput("ms_exp_a", 32'(oSel), 32'd3);
    tick();
    checkOutput("ms_exp_b", 32'(oSel), 32'd3);
    applyStimulus(4'b1111, 1'b1, 3'd0, 1'b1);
    tick();
    checkOutput("ms_rr2", 32'(oSel), 32'd2);

    // Idle: output drains, data and select stay put.
    applyStimulus(4'b0000, 1'b1, 3'd0, 1'b1);
    #1 checkOutput("idle_ready", 32'(oReady), 32'd0);
    tick();
    checkOutput("idle_valid", 32'(oValid), 32'd0);
    checkOutput("idle_sel",   32'(oSel),   32'd2);
    checkOutput("idle_data",  oData,       32'hA5A5_0002);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NCH; k++) chDataTb[k] = $urandom;
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                    3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) begin
        #1 iReset_n = 1'b0;
        #1 iReset_n = 1'b1;
      end
      tick();
    end

    compareOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
